// File: rtl/pc_cycle_sequencer.sv
// ============================================================================
// pc_cycle_sequencer
// ----------------------------------------------------------------------------
// Machine-cycle sequencer for the TB4004 program counter / 8-level address
// stack. It steps the eight clock phases A1 A2 A3 M1 M2 X1 X2 X3, latches the
// OPR/OPA nibbles from the ROM bus, and drives the PC-stack control lines for
// JUN, JMS, BBL, JCN, ISZ and the two-word FIM. SYNC is raised during X3.
//
// All outputs are registered. Each one is decoded from the *next* state and
// latch values, so it shows the decode of the current state with no
// combinational path from bus_in, run or branch_take to any output.
//
// Build option: SEQ_STACK_GUARD_EN
//   defined   - a 3-bit depth counter tracks pc_push/pc_pop, saturating at
//               0..STACK_DEPTH. Sticky stk_ovf/stk_unf flag a push at full
//               and a pop at empty.
//   undefined - no counter; stk_ovf and stk_unf are tied to 0.
//
// Parameters
//   STACK_DEPTH  usable return levels of the PC stack (1..7)
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   asynchronous, active-low
//   run          in   start/continue machine cycles (sampled in IDLE and X3)
//   bus_in[3:0]  in   ROM nibble: OPR in M1, OPA in M2
//   branch_take  in   JCN condition / ISZ nonzero, sampled in X1 of 2nd word
//   phase[2:0]   out  0..7 = A1..X3 (0 in IDLE)
//   idle         out  1 while idle
//   sync         out  1 during X3
//   pc_push      out  PC stack push
//   pc_pop       out  PC stack pop
//   pc_inc       out  PC stack increment
//   pc_load      out  PC stack nibble load
//   pc_sel[1:0]  out  PC nibble select: 00 low, 01 mid, 10 high
//   pc_data[3:0] out  PC stack data_in
//   opr, opa     out  latched opcode nibbles of the current word
//   second_word  out  executing the 2nd word of a two-word instruction
//   stk_ovf      out  sticky push-at-full (guard build only)
//   stk_unf      out  sticky pop-at-empty (guard build only)
// ============================================================================
module pc_cycle_sequencer #(
    parameter int STACK_DEPTH = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [3:0] bus_in,
    input  logic       branch_take,
    output logic [2:0] phase,
    output logic       idle,
    output logic       sync,
    output logic       pc_push,
    output logic       pc_pop,
    output logic       pc_inc,
    output logic       pc_load,
    output logic [1:0] pc_sel,
    output logic [3:0] pc_data,
    output logic [3:0] opr,
    output logic [3:0] opa,
    output logic       second_word,
    output logic       stk_ovf,
    output logic       stk_unf
);

    // The depth counter is three bits wide.
    if (STACK_DEPTH < 1 || STACK_DEPTH > 7) begin : g_bad_depth
        $error("pc_cycle_sequencer: STACK_DEPTH must be in 1..7");
    end

    typedef enum logic [3:0] {
        S_IDLE, S_A1, S_A2, S_A3, S_M1, S_M2, S_X1, S_X2, S_X3
    } state_t;

    // Pending second-word action. It is captured when the first word ends,
    // because opr/opa are overwritten by the second word.
    typedef enum logic [2:0] {
        K_NONE, K_JUN, K_JMS, K_COND, K_FIM
    } kind_t;

    typedef struct packed {
        logic [2:0] phase;
        logic       idle;
        logic       sync;
        logic       push;
        logic       pop;
        logic       inc;
        logic       load;
        logic [1:0] sel;
        logic [3:0] data;
    } outs_t;

    state_t     state, state_nxt;
    kind_t      kind, kind_nxt;
    logic [3:0] opr_nxt, opa_nxt;
    logic [3:0] hi_save, hi_save_nxt;
    logic       second_nxt;
    logic       take, take_nxt;
    outs_t      outs_nxt;

    function automatic kind_t classify(input logic [3:0] op_r, input logic [3:0] op_a);
        kind_t k;
        case (op_r)
            4'h1, 4'h7: k = K_COND;
            4'h2:       k = op_a[0] ? K_NONE : K_FIM;   // SRC (opa odd) is one word
            4'h4:       k = K_JUN;
            4'h5:       k = K_JMS;
            default:    k = K_NONE;
        endcase
        return k;
    endfunction

    function automatic outs_t decode(input state_t st, input logic sw, input kind_t k,
                                     input logic tk, input logic [3:0] o_r,
                                     input logic [3:0] o_a, input logic [3:0] hi);
        outs_t d;
        logic  jump;
        logic  xfer;
        d    = '0;
        jump = sw && (k == K_JUN || k == K_JMS);
        // Conditional branches only reload the mid and low nibbles.
        xfer = jump || (sw && k == K_COND && tk);
        case (st)
            S_IDLE: d.idle = 1'b1;
            S_A1: begin
                d.phase = 3'd0;
                d.sel   = 2'b00;
            end
            S_A2: begin
                d.phase = 3'd1;
                d.sel   = 2'b01;
            end
            S_A3: begin
                d.phase = 3'd2;
                d.sel   = 2'b10;
                d.inc   = 1'b1;
            end
            S_M1: d.phase = 3'd3;
            S_M2: begin
                d.phase = 3'd4;
                // PC already points past the second word: this is the return address.
                d.push  = sw && (k == K_JMS);
            end
            S_X1: begin
                d.phase = 3'd5;
                if (jump) begin
                    d.load = 1'b1;
                    d.sel  = 2'b10;
                    d.data = hi;
                end else if (!sw && o_r == 4'hC) begin
                    d.pop = 1'b1;
                end
            end
            S_X2: begin
                d.phase = 3'd6;
                if (xfer) begin
                    d.load = 1'b1;
                    d.sel  = 2'b01;
                    d.data = o_r;
                end
            end
            S_X3: begin
                d.phase = 3'd7;
                d.sync  = 1'b1;
                if (xfer) begin
                    d.load = 1'b1;
                    d.sel  = 2'b00;
                    d.data = o_a;
                end
            end
            default: d.idle = 1'b1;
        endcase
        return d;
    endfunction

    always_comb begin
        state_nxt   = state;
        opr_nxt     = opr;
        opa_nxt     = opa;
        hi_save_nxt = hi_save;
        take_nxt    = take;
        second_nxt  = second_word;
        kind_nxt    = kind;
        case (state)
            S_IDLE: if (run) state_nxt = S_A1;
            S_A1:   state_nxt = S_A2;
            S_A2:   state_nxt = S_A3;
            S_A3:   state_nxt = S_M1;
            S_M1: begin
                state_nxt = S_M2;
                opr_nxt   = bus_in;
            end
            S_M2: begin
                state_nxt = S_X1;
                opa_nxt   = bus_in;
                if (!second_word) hi_save_nxt = bus_in;
            end
            S_X1: begin
                state_nxt = S_X2;
                take_nxt  = branch_take;
            end
            S_X2:   state_nxt = S_X3;
            S_X3: begin
                state_nxt = run ? S_A1 : S_IDLE;
                // A second word is never decoded as an instruction itself.
                if (second_word) begin
                    second_nxt = 1'b0;
                    kind_nxt   = K_NONE;
                end else begin
                    kind_nxt   = classify(opr, opa);
                    second_nxt = (kind_nxt != K_NONE);
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        outs_nxt = decode(state_nxt, second_nxt, kind_nxt, take_nxt,
                          opr_nxt, opa_nxt, hi_save_nxt);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            kind        <= K_NONE;
            opr         <= 4'h0;
            opa         <= 4'h0;
            hi_save     <= 4'h0;
            take        <= 1'b0;
            second_word <= 1'b0;
            phase       <= 3'd0;
            idle        <= 1'b1;
            sync        <= 1'b0;
            pc_push     <= 1'b0;
            pc_pop      <= 1'b0;
            pc_inc      <= 1'b0;
            pc_load     <= 1'b0;
            pc_sel      <= 2'b00;
            pc_data     <= 4'h0;
        end else begin
            state       <= state_nxt;
            kind        <= kind_nxt;
            opr         <= opr_nxt;
            opa         <= opa_nxt;
            hi_save     <= hi_save_nxt;
            take        <= take_nxt;
            second_word <= second_nxt;
            phase       <= outs_nxt.phase;
            idle        <= outs_nxt.idle;
            sync        <= outs_nxt.sync;
            pc_push     <= outs_nxt.push;
            pc_pop      <= outs_nxt.pop;
            pc_inc      <= outs_nxt.inc;
            pc_load     <= outs_nxt.load;
            pc_sel      <= outs_nxt.sel;
            pc_data     <= outs_nxt.data;
        end
    end

`ifdef SEQ_STACK_GUARD_EN
    localparam logic [2:0] DEPTH_MAX = 3'(STACK_DEPTH);

    logic [2:0] depth;
    logic       ovf_q;
    logic       unf_q;

    // Follows the issued requests. The request itself is never suppressed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            depth <= 3'd0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (pc_push) begin
            if (depth == DEPTH_MAX) ovf_q <= 1'b1;
            else                    depth <= depth + 3'd1;
        end else if (pc_pop) begin
            if (depth == 3'd0) unf_q <= 1'b1;
            else               depth <= depth - 3'd1;
        end
    end

    assign stk_ovf = ovf_q;
    assign stk_unf = unf_q;
`else
    assign stk_ovf = 1'b0;
    assign stk_unf = 1'b0;
`endif

endmodule
